// File: rtl/apb_modport_pkg.sv
// Shared definitions for the APB register-block slave: bus widths, ID word and FSM states.
// The optional APB_WAIT_STATE_EN build adds one wait state per transfer (WAIT state).
package apb_modport_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;

    localparam logic [7:0]  ID_ADDR  = 8'hFC;
    localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT
    } apb_state_e;

endpackage

// File: rtl/apb_modport_regfile.sv
// 63-word read/write storage with a read-only ID word decoded at the top word index.
// Synchronous write port, combinational read port; storage clears on reset.
module apb_modport_regfile
    import apb_modport_pkg::*;
#(
    parameter int                    DATA_WIDTH = apb_modport_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = apb_modport_pkg::ID_VALUE
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  we,
    input  logic [5:0]            widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [5:0]            ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:62];

    // Index 63 is the ID word and has no backing storage, so writes there are dropped.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < 63; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (widx != 6'd63)) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = (ridx == 6'd63) ? ID_VALUE : mem[ridx];

endmodule

// File: rtl/apb_modport_slave.sv
// APB3 completer fronting a 64-word register file with a read-only ID word and error signalling.
// Define APB_WAIT_STATE_EN to insert exactly one wait state per transfer.
module apb_modport_slave #(
    parameter int                    ADDR_WIDTH = apb_modport_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = apb_modport_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = apb_modport_pkg::ID_VALUE
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    import apb_modport_pkg::*;

    apb_state_e            state;
    logic [5:0]            idx;
    logic                  misaligned;
    logic                  id_hit;
    logic                  err;
    logic                  setup_phase;
    logic                  access_phase;
    logic                  complete;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;

    assign idx          = paddr[7:2];
    assign misaligned   = |paddr[1:0];
    assign id_hit       = (idx == ID_ADDR[7:2]);
    assign err          = misaligned | (pwrite & id_hit);
    assign setup_phase  = psel & ~penable;
    assign access_phase = psel & penable;
    assign complete     = access_phase & pready;
    assign pslverr      = complete & err;
    assign we           = complete & pwrite & ~err;

    apb_modport_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .pclk     (pclk),
        .preset_n (preset_n),
        .we       (we),
        .widx     (idx),
        .wdata    (pwdata),
        .ridx     (idx),
        .rdata    (rdata)
    );

`ifndef APB_WAIT_STATE_EN
    assign pready = 1'b1;
`endif

    // State records the bus phase seen at the last edge; prdata is captured on the SETUP edge of reads.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state  <= IDLE;
            prdata <= '0;
`ifdef APB_WAIT_STATE_EN
            pready <= 1'b0;
`endif
        end else begin
`ifdef APB_WAIT_STATE_EN
            pready <= 1'b0;
`endif
            if (setup_phase && !pwrite) begin
                prdata <= misaligned ? '0 : rdata;
            end
            case (state)
                IDLE: begin
                    if (setup_phase) state <= SETUP;
                end
                SETUP: begin
                    if (access_phase) begin
`ifdef APB_WAIT_STATE_EN
                        state  <= WAIT;
                        pready <= 1'b1;
`else
                        state  <= ACCESS;
`endif
                    end else if (!setup_phase) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    state <= access_phase ? ACCESS : IDLE;
                end
                ACCESS: begin
                    state <= setup_phase ? SETUP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_modport_slave.sv
// Directed scoreboard bench for apb_modport_slave; expectations are queued at drive time.
// Honours APB_WAIT_STATE_EN for transfer length and reset value of pready.
module tb_apb_modport_slave;

`ifdef APB_WAIT_STATE_EN
    localparam int   EXP_CYC       = 3;
    localparam logic EXP_RST_READY = 1'b0;
`else
    localparam int   EXP_CYC       = 2;
    localparam logic EXP_RST_READY = 1'b1;
`endif

    typedef struct {
        string       tag;
        logic        is_read;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        pclk;
    logic        preset_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    apb_modport_slave dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Pops the oldest expectation and compares it against the completing ACCESS cycle.
    task automatic checkOutput(input int cyc);
        exp_t e;
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        checkVal({e.tag, "_pready"}, {31'd0, pready}, 32'd1);
        checkVal({e.tag, "_cycles"}, cyc, EXP_CYC);
        checkVal({e.tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
        if (e.is_read) checkVal({e.tag, "_prdata"}, prdata, e.data);
    endtask

    // One APB transfer starting at the next falling edge, no idle cycle inserted before it.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input logic exp_err, input string tag);
        int n;
        sb.push_back('{tag, !wr, exp_data, exp_err});
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        #1;
        checkVal({tag, "_setup_err"}, {31'd0, pslverr}, 32'd0);
        @(negedge pclk);
        penable = 1'b1;
        #1;
        n = 2;
        while (pready !== 1'b1 && n < EXP_CYC + 3) begin
            @(negedge pclk);
            #1;
            n++;
        end
        checkOutput(n);
    endtask

    task automatic busIdle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        #1;
        checkVal("idle_pslverr", {31'd0, pslverr}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        repeat (3) @(negedge pclk);
        #1;
        checkVal("rst_prdata", prdata, 32'd0);
        checkVal("rst_pslverr", {31'd0, pslverr}, 32'd0);
        checkVal("rst_pready", {31'd0, pready}, {31'd0, EXP_RST_READY});
        @(negedge pclk);
        preset_n = 1'b1;

        applyStimulus(1'b0, 8'h10, 32'h0, 32'h0000_0000, 1'b0, "rd10_rst");
        applyStimulus(1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr10");
        applyStimulus(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10");
        busIdle();

        applyStimulus(1'b0, 8'hFC, 32'h0, 32'hA5B0_0001, 1'b0, "rd_id");
        applyStimulus(1'b1, 8'hFC, 32'h1234_5678, 32'h0, 1'b1, "wr_id");
        applyStimulus(1'b0, 8'hFC, 32'h0, 32'hA5B0_0001, 1'b0, "rd_id_again");
        busIdle();

        applyStimulus(1'b1, 8'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr_mis13");
        applyStimulus(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10_after_mis");
        applyStimulus(1'b0, 8'h11, 32'h0, 32'h0000_0000, 1'b1, "rd_mis11");
        busIdle();

        // penable with psel low must not write anything.
        @(negedge pclk);
        psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h5555_AAAA;
        @(negedge pclk);
        penable = 1'b0;
        applyStimulus(1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd10_no_psel");
        busIdle();

        for (int a = 0; a < 252; a += 4) begin
            applyStimulus(1'b1, a[7:0], 32'(a * 3), 32'h0, 1'b0, "b2b_wr");
        end
        for (int a = 0; a < 252; a += 4) begin
            applyStimulus(1'b0, a[7:0], 32'h0, 32'(a * 3), 1'b0, "b2b_rd");
        end
        busIdle();

        applyStimulus(1'b1, 8'h20, 32'h0BAD_F00D, 32'h0, 1'b0, "wr20");
        applyStimulus(1'b0, 8'h20, 32'h0, 32'h0BAD_F00D, 1'b0, "rd20");
        busIdle();

        // Reset asserted during the ACCESS phase of a read of 0x20.
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h20;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        preset_n = 1'b0;
        #1;
        checkVal("midrst_pready", {31'd0, pready}, {31'd0, EXP_RST_READY});
        checkVal("midrst_prdata", prdata, 32'd0);
        checkVal("midrst_pslverr", {31'd0, pslverr}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        preset_n = 1'b1;
        applyStimulus(1'b0, 8'h20, 32'h0, 32'h0000_0000, 1'b0, "rd20_after_rst");
        applyStimulus(1'b0, 8'hFC, 32'h0, 32'hA5B0_0001, 1'b0, "rd_id_after_rst");
        busIdle();

        checkVal("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
